dcnn_host_link: RTL and testbench

Synthesizable host-side link that replaces the behavioural host model feeding the DCNN accelerator's IO unit. It buffers compressed words from an on-chip source, then streams them to the IO unit as a sequence of channels: channel 0 is CNN weights, channel 1 is the image, and further channels are optional. Each channel starts with an interrupt-framed command and proceeds one word per `done` handshake. A final process command closes the sequence. Unlike the old model, it handles every enabled channel in order, has a configurable bus width and length per channel, and applies backpressure on its source.

---
 rtl/dcnn_link_pkg.sv | 21 ++
 rtl/link_fifo.sv | 73 +++++++
 rtl/dcnn_host_link.sv | 204 ++++++++++++++++++++
 tb/tb_dcnn_host_link.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcnn_link_pkg.sv
// dcnn_link_pkg: shared types and constants for the DCNN host link.
//   link_state_e    - host link FSM states
//   CH_CNN/CH_IMAGE - fixed channel numbers for weights and image
//   DefaultDataW/DefaultLenW - default bus and length widths
package dcnn_link_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultLenW  = 16;

  localparam int unsigned CH_CNN   = 0;
  localparam int unsigned CH_IMAGE = 1;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StXfer,
    StProc,
    StFin
  } link_state_e;

endpackage

// File: rtl/link_fifo.sv
// link_fifo: synchronous FIFO with count-based flags, first-word fall-through read.
//   clk_i, rst (sync, active-low)
//   flush_i          - drop all contents
//   push_i, wdata_i  - write side (push while full is taken only with a pop)
//   pop_i, rdata_o   - read side, rdata_o shows the head word
//   empty_o          - no words stored
//   ready_o          - registered "not full", low while in reset
module link_fifo
  import dcnn_link_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              ready_o
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q;
  logic              full, do_push, do_pop;

  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign ready_o = ready_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != CntW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dcnn_host_link.sv
// dcnn_host_link: buffers source words and streams them to the DCNN IO unit channel by
// channel (channel 0 = CNN weights, 1 = image), each framed by an interrupt command,
// followed by a final process command.
//   clk_i, rst (sync, active-low)
//   start_i, ch_en_i, ch_len_i             - sequence request, sampled in idle
//   src_valid_i, src_data_i, src_ready_o   - source stream with backpressure
//   done_i                                 - IO unit consumed data_o
//   interrupt_o, load_o, ch_sel_o, data_o  - IO unit command/data bus
//   busy_o, finished_o, error_o            - status
// Optional build macro HOST_LINK_TIMEOUT_EN adds a done watchdog that sets error_o.
module dcnn_host_link
  import dcnn_link_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned LEN_W      = DefaultLenW,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH*LEN_W-1:0] ch_len_i,
  input  logic                    src_valid_i,
  input  logic [DATA_W-1:0]       src_data_i,
  output logic                    src_ready_o,
  input  logic                    done_i,
  output logic                    interrupt_o,
  output logic                    load_o,
  output logic [CH_W-1:0]         ch_sel_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    busy_o,
  output logic                    finished_o,
  output logic                    error_o
);

  link_state_e             state_q;
  logic [CH_W-1:0]         cur_q, ch_sel_q;
  logic [NUM_CH-1:0]       rem_q, rem_next, qual_in;
  logic [NUM_CH*LEN_W-1:0] len_q;
  logic [LEN_W-1:0]        sent_q, cur_len;
  logic [DATA_W-1:0]       data_q, fifo_rdata;
  logic                    pending_q, int_q, load_q, busy_q, fin_q;
  logic                    fifo_empty, fifo_pop, timeout_hit;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // A channel qualifies only when enabled and carrying at least one word.
  always_comb begin
    qual_in = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      qual_in[i] = ch_en_i[i] && (ch_len_i[i*LEN_W +: LEN_W] != '0);
    end
  end

  assign rem_next = rem_q & ~(NUM_CH'(1) << cur_q);
  assign cur_len  = len_q[int'(cur_q)*LEN_W +: LEN_W];
  assign fifo_pop = !fifo_empty &&
                    ((state_q == StArm) ||
                     (state_q == StXfer && !pending_q && sent_q != cur_len));

  link_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst    (rst),
    .flush_i(timeout_hit),
    .push_i (src_valid_i && src_ready_o),
    .wdata_i(src_data_i),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .ready_o(src_ready_o)
  );

`ifdef HOST_LINK_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TmrW-1:0] wdog_q;
  logic            err_q;

  // Watchdog restarts on every new word and only advances while a word is unanswered.
  assign timeout_hit = (state_q == StXfer) && pending_q && !done_i &&
                       (wdog_q == TmrW'(TIMEOUT - 1));
  assign error_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (fifo_pop || !pending_q) begin
        wdog_q <= '0;
      end else if (state_q == StXfer) begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (state_q == StIdle && start_i) begin
        err_q <= 1'b0;
      end else if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign error_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      sent_q    <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
      ch_sel_q  <= '0;
      int_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      int_q <= 1'b0;
      fin_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_q <= 1'b1;
            len_q  <= ch_len_i;
            rem_q  <= qual_in;
            cur_q  <= lowest_set(qual_in);
            if (qual_in != '0) begin
              state_q <= StArm;
            end else begin
              state_q <= StProc;
              int_q   <= 1'b1;
              load_q  <= 1'b0;
            end
          end
        end
        StArm: begin
          if (!fifo_empty) begin
            data_q    <= fifo_rdata;
            ch_sel_q  <= cur_q;
            load_q    <= 1'b1;
            int_q     <= 1'b1;
            pending_q <= 1'b1;
            sent_q    <= LEN_W'(1);
            state_q   <= StXfer;
          end
        end
        StXfer: begin
          if (timeout_hit) begin
            state_q <= StFin;
            fin_q   <= 1'b1;
          end else if (pending_q) begin
            if (done_i) pending_q <= 1'b0;
          end else if (sent_q == cur_len) begin
            rem_q <= rem_next;
            if (rem_next != '0) begin
              cur_q   <= lowest_set(rem_next);
              state_q <= StArm;
            end else begin
              state_q <= StProc;
              int_q   <= 1'b1;
              load_q  <= 1'b0;
            end
          end else if (!fifo_empty) begin
            data_q    <= fifo_rdata;
            pending_q <= 1'b1;
            sent_q    <= sent_q + 1'b1;
          end
        end
        StProc: begin
          state_q <= StFin;
          fin_q   <= 1'b1;
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign interrupt_o = int_q;
  assign load_o      = load_q;
  assign ch_sel_o    = ch_sel_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign finished_o  = fin_q;

endmodule

// File: tb/tb_dcnn_host_link.sv
// tb_dcnn_host_link: directed self-checking bench for dcnn_host_link.
module tb_dcnn_host_link;

  localparam int unsigned DW    = 16;
  localparam int unsigned NCH   = 2;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;

  logic              clk_i = 1'b0;
  logic              rst = 1'b0;
  logic              start_i = 1'b0;
  logic [NCH-1:0]    ch_en_i = '0;
  logic [NCH*LW-1:0] ch_len_i = '0;
  logic              src_valid_i = 1'b0;
  logic [DW-1:0]     src_data_i = '0;
  logic              src_ready_o;
  logic              done_i = 1'b0;
  logic              interrupt_o, load_o, busy_o, finished_o, error_o;
  logic [0:0]        ch_sel_o;
  logic [DW-1:0]     data_o;

  always #5 clk_i = ~clk_i;

  dcnn_host_link #(
    .DATA_W    (DW),
    .NUM_CH    (NCH),
    .LEN_W     (LW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .start_i    (start_i),
    .ch_en_i    (ch_en_i),
    .ch_len_i   (ch_len_i),
    .src_valid_i(src_valid_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .done_i     (done_i),
    .interrupt_o(interrupt_o),
    .load_o     (load_o),
    .ch_sel_o   (ch_sel_o),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .finished_o (finished_o),
    .error_o    (error_o)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] words[$];
  logic [DW-1:0] exp_w[$];
  int            irq_ch[$];
  logic          irq_load[$];
  logic [DW-1:0] irq_data[$];
  int            irq_cyc[$];
  bit            got_fin;

  task automatic src_drive();
    src_valid_i = (src_q.size() > 0);
    if (src_q.size() > 0) src_data_i = src_q[0];
    else src_data_i = '0;
  endtask

  // One clock: retire an accepted source word, then re-drive the source.
  task automatic step();
    logic acc;
    acc = src_valid_i && src_ready_o;
    @(posedge clk_i);
    #1;
    if (acc) src_q.delete(0);
    src_drive();
  endtask

  task automatic preload();
    src_drive();
    for (int i = 0; i < 40 && src_q.size() > 0; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start_i = 1'b0;
    done_i = 1'b0;
    src_q.delete();
    src_drive();
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_start(input logic [NCH-1:0] en, input logic [LW-1:0] l0,
                          input logic [LW-1:0] l1);
    ch_en_i  = en;
    ch_len_i = {l1, l0};
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  // Runs the IO-unit side: logs interrupts and presented words, answers done.
  task automatic run_collect(input int max_cyc, input int done_lat, input bit force_done,
                             input int start_at);
    int due;
    logic [DW-1:0] prev;
    words.delete();
    irq_ch.delete();
    irq_load.delete();
    irq_data.delete();
    irq_cyc.delete();
    got_fin = 1'b0;
    due = -1;
    prev = data_o;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (interrupt_o) begin
        irq_ch.push_back(int'(ch_sel_o));
        irq_load.push_back(load_o);
        irq_data.push_back(data_o);
        irq_cyc.push_back(c);
      end
      if (busy_o && ((interrupt_o && load_o) || data_o !== prev)) begin
        words.push_back(data_o);
        due = c + done_lat;
      end
      prev = data_o;
      done_i = force_done || (c == due);
      start_i = (c == start_at);
      if (finished_o) begin
        got_fin = 1'b1;
        break;
      end
    end
    done_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({interrupt_o, load_o, ch_sel_o, data_o, busy_o, finished_o, error_o, src_ready_o}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs got irq=%b load=%b ch=%b data=%h busy=%b fin=%b err=%b rdy=%b want all 0",
               interrupt_o, load_o, ch_sel_o, data_o, busy_o, finished_o, error_o, src_ready_o);
    end
    do_reset();
  endtask

  task automatic test_two_channels();
    bit ok;
    src_q = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    preload();
    do_start(2'b11, 16'd3, 16'd2);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL t1_busy_after_start got %b want 1", busy_o);
    end
    run_collect(200, 1, 1'b0, -1);
    checks++;
    if (irq_ch.size() != 3) begin
      errors++;
      $display("FAIL t1_irq_count got %0d want 3", irq_ch.size());
    end
    checks++;
    if (irq_ch.size() < 1 || irq_cyc[0] != 0 || irq_ch[0] != 0 || irq_load[0] !== 1'b1 ||
        irq_data[0] !== 16'h1111) begin
      errors++;
      $display("FAIL t1_first_arm got cyc=%0d ch=%0d load=%b data=%h want cyc=0 ch=0 load=1 data=1111",
               irq_cyc[0], irq_ch[0], irq_load[0], irq_data[0]);
    end
    checks++;
    if (irq_ch.size() < 2 || irq_ch[1] != 1 || irq_load[1] !== 1'b1 ||
        irq_data[1] !== 16'h4444) begin
      errors++;
      $display("FAIL t1_second_arm got ch=%0d load=%b data=%h want ch=1 load=1 data=4444",
               irq_ch[1], irq_load[1], irq_data[1]);
    end
    checks++;
    if (irq_ch.size() < 3 || irq_load[2] !== 1'b0) begin
      errors++;
      $display("FAIL t1_proc got load=%b want 0", irq_load[2]);
    end
    exp_w = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    ok = (words.size() == exp_w.size());
    for (int i = 0; i < words.size() && i < exp_w.size(); i++) if (words[i] !== exp_w[i]) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t1_words got n=%0d first=%h want n=5 first=1111", words.size(), words[0]);
    end
    checks++;
    if (got_fin !== 1'b1 || error_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_finished got fin=%b err=%b want fin=1 err=0", got_fin, error_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || finished_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle_after got busy=%b fin=%b want 0 0", busy_o, finished_o);
    end
  endtask

  task automatic test_skip_channels();
    src_q = {16'h6666, 16'h7777};
    preload();
    do_start(2'b10, 16'd3, 16'd2);
    run_collect(100, 1, 1'b0, -1);
    checks++;
    if (irq_ch.size() != 2 || irq_ch[0] != 1 || irq_data[0] !== 16'h6666 ||
        words.size() != 2 || words[1] !== 16'h7777 || irq_load[1] !== 1'b0) begin
      errors++;
      $display("FAIL t2_disabled_ch0 got nirq=%0d ch=%0d data=%h nw=%0d want nirq=2 ch=1 data=6666 nw=2",
               irq_ch.size(), irq_ch[0], irq_data[0], words.size());
    end
    step();
    src_q = {16'h8888};
    preload();
    do_start(2'b11, 16'd0, 16'd1);
    run_collect(100, 1, 1'b0, -1);
    checks++;
    if (irq_ch.size() != 2 || irq_ch[0] != 1 || irq_data[0] !== 16'h8888 ||
        words.size() != 1 || !got_fin) begin
      errors++;
      $display("FAIL t2_zero_len_ch0 got nirq=%0d ch=%0d data=%h nw=%0d fin=%b want 2 1 8888 1 1",
               irq_ch.size(), irq_ch[0], irq_data[0], words.size(), got_fin);
    end
    step();
    do_start(2'b00, 16'd5, 16'd5);
    checks++;
    if (interrupt_o !== 1'b1 || load_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL t2_no_channel_proc got irq=%b load=%b busy=%b want 1 0 1",
               interrupt_o, load_o, busy_o);
    end
    step();
    checks++;
    if (finished_o !== 1'b1 || interrupt_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_no_channel_fin got fin=%b irq=%b want 1 0", finished_o, interrupt_o);
    end
    step();
  endtask

  task automatic test_stall_backpressure();
    bit stable;
    bit ok;
    do_reset();
    src_q = {16'hA000, 16'hA001};
    preload();
    do_start(2'b01, 16'd12, 16'd0);
    step();
    checks++;
    if (interrupt_o !== 1'b1 || data_o !== 16'hA000) begin
      errors++;
      $display("FAIL t3_first got irq=%b data=%h want 1 a000", interrupt_o, data_o);
    end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    checks++;
    if (data_o !== 16'hA001) begin
      errors++;
      $display("FAIL t3_second got %h want a001", data_o);
    end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (data_o !== 16'hA001 || interrupt_o !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL t3_stall_stable got data=%h irq=%b want a001 0", data_o, interrupt_o);
    end
    for (int i = 2; i <= 11; i++) src_q.push_back(16'hA000 + 16'(i));
    src_drive();
    for (int i = 0; i < 16; i++) step();
    checks++;
    if (src_ready_o !== 1'b0 || data_o !== 16'hA002 || src_q.size() != 1) begin
      errors++;
      $display("FAIL t3_full got rdy=%b data=%h left=%0d want rdy=0 data=a002 left=1",
               src_ready_o, data_o, src_q.size());
    end
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    run_collect(300, 1, 1'b0, -1);
    exp_w.delete();
    for (int i = 3; i <= 11; i++) exp_w.push_back(16'hA000 + 16'(i));
    ok = (words.size() == exp_w.size());
    for (int i = 0; i < words.size() && i < exp_w.size(); i++) if (words[i] !== exp_w[i]) ok = 0;
    checks++;
    if (!ok || irq_ch.size() != 1 || irq_load[0] !== 1'b0 || !got_fin) begin
      errors++;
      $display("FAIL t3_drain got nw=%0d first=%h nirq=%0d fin=%b want nw=9 first=a003 nirq=1 fin=1",
               words.size(), words[0], irq_ch.size(), got_fin);
    end
    step();
  endtask

  task automatic test_spurious_done_and_start();
    bit quiet;
    src_q = {16'hB000, 16'hB001, 16'hB002};
    preload();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    do_start(2'b01, 16'd2, 16'd0);
    run_collect(100, 0, 1'b1, 1);
    checks++;
    if (words.size() != 2 || words[0] !== 16'hB000 || words[1] !== 16'hB001 ||
        irq_ch.size() != 2 || irq_load[1] !== 1'b0 || !got_fin) begin
      errors++;
      $display("FAIL t4_words got nw=%0d w0=%h w1=%h nirq=%0d fin=%b want 2 b000 b001 2 1",
               words.size(), words[0], words[1], irq_ch.size(), got_fin);
    end
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy_o !== 1'b0 || interrupt_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL t4_no_restart got busy=%b irq=%b want 0 0", busy_o, interrupt_o);
    end
    do_start(2'b01, 16'd1, 16'd0);
    run_collect(100, 1, 1'b0, -1);
    checks++;
    if (words.size() != 1 || words[0] !== 16'hB002) begin
      errors++;
      $display("FAIL t4_surplus_kept got nw=%0d w0=%h want 1 b002", words.size(), words[0]);
    end
    step();
  endtask

  task automatic test_reset_mid_xfer();
    bit quiet;
    src_q = {16'hC000, 16'hC001, 16'hC002, 16'hC003};
    preload();
    do_start(2'b11, 16'd2, 16'd2);
    step();
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({interrupt_o, load_o, ch_sel_o, data_o, busy_o, finished_o, error_o, src_ready_o}
        !== '0) begin
      errors++;
      $display("FAIL t5_reset_outputs got irq=%b load=%b ch=%b data=%h busy=%b fin=%b err=%b rdy=%b want all 0",
               interrupt_o, load_o, ch_sel_o, data_o, busy_o, finished_o, error_o, src_ready_o);
    end
    rst = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (interrupt_o !== 1'b0 || finished_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL t5_no_proc_after_reset got irq=%b fin=%b want 0 0", interrupt_o, finished_o);
    end
    src_q = {16'hD00D};
    preload();
    do_start(2'b01, 16'd1, 16'd0);
    run_collect(100, 1, 1'b0, -1);
    checks++;
    if (words.size() != 1 || words[0] !== 16'hD00D || irq_ch.size() != 2 || !got_fin) begin
      errors++;
      $display("FAIL t5_restart got nw=%0d w0=%h nirq=%0d fin=%b want 1 d00d 2 1",
               words.size(), words[0], irq_ch.size(), got_fin);
    end
    step();
  endtask

`ifdef HOST_LINK_TIMEOUT_EN
  task automatic test_timeout();
    bit quiet;
    do_reset();
    src_q = {16'hE000, 16'hE001};
    preload();
    do_start(2'b01, 16'd3, 16'd0);
    step();
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (error_o !== 1'b0 || finished_o !== 1'b0 || interrupt_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL t6_before_timeout got err=%b fin=%b want 0 0", error_o, finished_o);
    end
    step();
    checks++;
    if (error_o !== 1'b1 || finished_o !== 1'b1 || interrupt_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_timeout got err=%b fin=%b irq=%b want 1 1 0",
               error_o, finished_o, interrupt_o);
    end
    step();
    checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b0 || interrupt_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_sticky got err=%b busy=%b irq=%b want 1 0 0", error_o, busy_o, interrupt_o);
    end
    src_q = {16'hF00F};
    preload();
    do_start(2'b01, 16'd1, 16'd0);
    checks++;
    if (error_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_error_clear got %b want 0", error_o);
    end
    run_collect(100, 1, 1'b0, -1);
    checks++;
    if (words.size() != 1 || words[0] !== 16'hF00F) begin
      errors++;
      $display("FAIL t6_flushed got nw=%0d w0=%h want 1 f00f", words.size(), words[0]);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_two_channels();
    test_skip_channels();
    test_stall_backpressure();
    test_spurious_done_and_start();
    test_reset_mid_xfer();
`ifdef HOST_LINK_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
